m_dm_rsp: RTL and testbench
===========================

Name: m_dm_rsp

Overview:
- Memory-side responder for the data-memory interface driven by the M-stage store unit: receives `data_addr` / `data_byteen` / `data_wdata`.
- Performs byte-enabled writes into a synchronous word array.
- Serves loads with a registered read path and sign/zero extension.
- Used as the DM model in CPU benches and as the on-chip DM in the single-chip build; flags misaligned and out-of-range accesses back to the pipeline.

Parameters:
- ADDR_WORDS, 3072, number of 32-bit words; valid byte addresses 0 .. 4*ADDR_WORDS-1 (0x0000_0000-0x0000_2FFF).
- IDX_W, 12, width of word index taken from data_addr[IDX_W+1:2].

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- data_addr  in  32  byte address of the current access (load or store).
- data_byteen  in  4  store byte enables; 4'b0000 = no store.
- data_wdata  in  32  store data, already lane-shifted by the store unit.
- ld_en  in  1  load request this cycle.
- ld_op  in  3  0=lw 1=lh 2=lhu 3=lb 4=lbu; 5-7 reserved (treated as lw).
- rd_valid  out  1  load result valid (one cycle after ld_en).
- rd_data  out  32  extended load result.
- exc_adel  out  1  load address exception, aligned with rd_valid.
- exc_ades  out  1  store address exception, pulse in cycle after the store.
- wr_cnt  out  16  count of committed stores, saturating at 16'hFFFF.

Behaviour:
- Reset (synchronous): every array word = 0.
  - rd_valid = 0, rd_data = 0, exc_adel = 0, exc_ades = 0, wr_cnt = 0.
  - Reset overrides any access in the same cycle: no write, no read response.
- Range check:
  - in_range = data_addr < 4*ADDR_WORDS.
  - Upper address bits beyond IDX_W+1 must be zero for in_range.
- Store, on edge N when data_byteen != 0:
  - Legal patterns: 1111 requires addr[1:0]=00; 0011 / 1100 require addr[0]=0 and must match addr[1]; single-bit patterns require byteen == 1<<addr[1:0].
  - Legal and in_range: write only enabled byte lanes of word addr[IDX_W+1:2]; wr_cnt += 1, saturating.
  - Otherwise: no array change, wr_cnt unchanged, exc_ades = 1 for cycle N+1 only.
- Load, ld_en at edge N, response during cycle N+1:
  - Latency exactly 1: rd_valid = 1 in N+1, 0 otherwise.
  - Raw word is read before any same-edge write. A simultaneous load and store to the same word returns the OLD word.
  - lw: raw word.
  - lh / lhu: half at addr[1] (0 = bits 15:0, 1 = bits 31:16), sign- / zero-extended.
  - lb / lbu: byte at addr[1:0], sign- / zero-extended.
  - Misaligned (lw with addr[1:0] != 0; lh / lhu with addr[0] = 1) or out of range: exc_adel = 1 and rd_data = 0 in N+1; rd_valid still 1.
- Back-to-back loads every cycle are fully pipelined: one result per cycle, no bubbles.
- ld_en = 0 and data_byteen = 0: idle; outputs return to 0 on the next edge. rd_data holds 0 when rd_valid = 0.
- No internal stalls, no backpressure: accepts one access per cycle unconditionally.

Test Plan:
- Reset, then lw @0x0 -> rd_valid = 1 next cycle, rd_data = 0x0000_0000, exc_adel = 0; wr_cnt = 0.
- sw 0x8765_4321 (byteen 1111) @0x10, then lb / lbu / lh / lhu / lw @0x13 / 0x13 / 0x12 / 0x12 / 0x10:
  - Results 0xFFFF_FF87, 0x0000_0087, 0xFFFF_8765, 0x0000_8765, 0x8765_4321.
  - wr_cnt = 1.
- sb byteen 0100, wdata 0x00AA_0000 @0x12 over that word -> lw @0x10 = 0x87AA_4321. Same-cycle lw + sb to 0x10 returns the pre-store word; the following lw returns the updated word.
- Store byteen 1111 @0x11 -> exc_ades pulse of exactly 1 cycle, no write, wr_cnt unchanged. Store @0x3000 -> exc_ades, no write.
- lw @0x2 and lh @0x5 -> exc_adel = 1, rd_data = 0, rd_valid = 1. lw @0x3000 -> exc_adel = 1.
- Four consecutive-cycle loads with reset asserted in the third cycle:
  - Responses for loads 1-2 appear normally.
  - Cycle after reset: rd_valid = 0, all memory words read 0 afterward, wr_cnt = 0.

Source files
------------

// File: rtl/m_dm_rsp_if.sv
// Data-memory access bundle between the M-stage store/load unit (master)
// and the memory responder (slave).
interface m_dm_rsp_if;
    logic [31:0] data_addr;
    logic [3:0]  data_byteen;
    logic [31:0] data_wdata;
    logic        ld_en;
    logic [2:0]  ld_op;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        exc_adel;
    logic        exc_ades;
    logic [15:0] wr_cnt;

    modport master (
        output data_addr, data_byteen, data_wdata, ld_en, ld_op,
        input  rd_valid, rd_data, exc_adel, exc_ades, wr_cnt
    );

    modport slave (
        input  data_addr, data_byteen, data_wdata, ld_en, ld_op,
        output rd_valid, rd_data, exc_adel, exc_ades, wr_cnt
    );
endinterface

// File: rtl/m_dm_rsp.sv
// Data-memory responder: byte-enabled stores into a word array, one-cycle
// registered loads with sign/zero extension, address exception flags.
module m_dm_rsp #(
    parameter int ADDR_WORDS = 3072,
    parameter int IDX_W      = 12
) (
    input  logic       clk,
    input  logic       reset,
    m_dm_rsp_if.slave  bus
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * ADDR_WORDS);

    logic [31:0] mem_q [ADDR_WORDS];

    logic        rd_valid_q, rd_valid_d;
    logic [31:0] rd_data_q,  rd_data_d;
    logic        exc_adel_q, exc_adel_d;
    logic        exc_ades_q, exc_ades_d;
    logic [15:0] wr_cnt_q,   wr_cnt_d;

    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic [31:0]      raw;
    logic             store_req;
    logic             store_ok;
    logic             ld_bad;

    function automatic logic store_legal(input logic [3:0] be, input logic [1:0] o);
        logic ok;
        case (be)
            4'b1111:                            ok = (o == 2'b00);
            4'b0011:                            ok = (o == 2'b00);
            4'b1100:                            ok = (o == 2'b10);
            4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = (be == (4'b0001 << o));
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Reserved opcodes behave as lw, including the alignment rule.
    function automatic logic load_misaligned(input logic [2:0] op, input logic [1:0] o);
        logic bad;
        case (op)
            3'd1, 3'd2: bad = o[0];
            3'd3, 3'd4: bad = 1'b0;
            default:    bad = (o != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] op,
                                                input logic [1:0] o);
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = o[1] ? w[31:16] : w[15:0];
        b = 8'(w >> {o, 3'b000});
        case (op)
            3'd1:    r = {{16{h[15]}}, h};
            3'd2:    r = {16'h0000, h};
            3'd3:    r = {{24{b[7]}}, b};
            3'd4:    r = {24'h000000, b};
            default: r = w;
        endcase
        return r;
    endfunction

    always_comb begin
        in_range  = (bus.data_addr < ADDR_LIMIT);
        idx       = bus.data_addr[IDX_W+1:2];
        off       = bus.data_addr[1:0];
        raw       = in_range ? mem_q[idx] : 32'h0;
        store_req = (bus.data_byteen != 4'b0000);
        store_ok  = store_req && in_range && store_legal(bus.data_byteen, off);
        ld_bad    = !in_range || load_misaligned(bus.ld_op, off);

        rd_valid_d = bus.ld_en;
        exc_adel_d = bus.ld_en && ld_bad;
        rd_data_d  = (bus.ld_en && !ld_bad) ? load_extend(raw, bus.ld_op, off) : 32'h0;
        exc_ades_d = store_req && !store_ok;
        wr_cnt_d   = (store_ok && wr_cnt_q != 16'hFFFF) ? wr_cnt_q + 16'd1 : wr_cnt_q;
    end

    // Array read above sees the pre-edge contents, so a same-edge load gets the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ADDR_WORDS; i++) mem_q[i] <= 32'h0;
        end else if (store_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_byteen[b]) mem_q[idx][8*b +: 8] <= bus.data_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'h0;
            exc_adel_q <= 1'b0;
            exc_ades_q <= 1'b0;
            wr_cnt_q   <= 16'h0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            exc_adel_q <= exc_adel_d;
            exc_ades_q <= exc_ades_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.exc_adel = exc_adel_q;
    assign bus.exc_ades = exc_ades_q;
    assign bus.wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_m_dm_rsp.sv
// Bench for m_dm_rsp: directed vector table, hand-written corner sequences,
// then random traffic against a word-array reference model.
module tb_m_dm_rsp;

    localparam int ADDR_WORDS = 3072;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    m_dm_rsp_if bus ();

    m_dm_rsp #(.ADDR_WORDS(ADDR_WORDS), .IDX_W(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        ld;
        logic [2:0]  op;
        logic        e_vld;
        logic [31:0] e_rd;
        logic        e_adel;
        logic        e_ades;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int unsigned model_mem [ADDR_WORDS];
    int unsigned model_cnt;

    function automatic vec_t mk(string nm, logic [31:0] a, logic [3:0] be, logic [31:0] wd,
                                logic ld, logic [2:0] op, logic ev, logic [31:0] erd,
                                logic eadel, logic eades, logic [15:0] ecnt);
        vec_t v;
        v.name = nm; v.addr = a; v.be = be; v.wd = wd; v.ld = ld; v.op = op;
        v.e_vld = ev; v.e_rd = erd; v.e_adel = eadel; v.e_ades = eades; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic drive(logic [31:0] a, logic [3:0] be, logic [31:0] wd, logic ld, logic [2:0] op);
        bus.data_addr   = a;
        bus.data_byteen = be;
        bus.data_wdata  = wd;
        bus.ld_en       = ld;
        bus.ld_op       = op;
    endtask

    task automatic check(string nm, logic ev, logic [31:0] erd, logic eadel, logic eades,
                         logic [15:0] ecnt);
        n_checks++;
        if (bus.rd_valid !== ev || bus.rd_data !== erd || bus.exc_adel !== eadel ||
            bus.exc_ades !== eades || bus.wr_cnt !== ecnt) begin
            n_fail++;
            $display("FAIL %s: got vld=%b rd=%h adel=%b ades=%b cnt=%h, want vld=%b rd=%h adel=%b ades=%b cnt=%h",
                     nm, bus.rd_valid, bus.rd_data, bus.exc_adel, bus.exc_ades, bus.wr_cnt,
                     ev, erd, eadel, eades, ecnt);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: one access per cycle, computed from the architectural rules.
    task automatic model_access(logic [31:0] a, logic [3:0] be, logic [31:0] wd, logic ld,
                                logic [2:0] op, output logic ev, output logic [31:0] erd,
                                output logic eadel, output logic eades);
        int unsigned word, sz, lsz, o, val;
        bit          inr, legal, sgn;
        inr  = (a < 4 * ADDR_WORDS);
        o    = a % 4;
        word = inr ? model_mem[a / 4] : 0;
        ev = ld; erd = 0; eadel = 0; eades = 0;
        if (ld) begin
            case (op)
                3'd1: begin lsz = 2; sgn = 1; end
                3'd2: begin lsz = 2; sgn = 0; end
                3'd3: begin lsz = 1; sgn = 1; end
                3'd4: begin lsz = 1; sgn = 0; end
                default: begin lsz = 4; sgn = 0; end
            endcase
            if (!inr || (a % lsz) != 0) begin
                eadel = 1;
            end else if (lsz == 4) begin
                erd = word;
            end else begin
                val = (word >> (8 * o)) & ((1 << (8 * lsz)) - 1);
                if (sgn && val >= (1 << (8 * lsz - 1))) val = val - (1 << (8 * lsz));
                erd = val;
            end
        end
        if (be != 0) begin
            sz    = $countones(be);
            legal = inr && (sz == 1 || sz == 2 || sz == 4) && (a % sz == 0) &&
                    (int'(be) == (((1 << sz) - 1) << o));
            if (legal) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) word = (word & ~(32'hFF << (8 * b))) | (wd & (32'hFF << (8 * b)));
                model_mem[a / 4] = word;
                if (model_cnt < 16'hFFFF) model_cnt++;
            end else begin
                eades = 1;
            end
        end
    endtask

    initial begin
        logic        ev, eadel, eades;
        logic [31:0] erd, a, wd;
        logic [3:0]  be;
        logic        ld;
        logic [2:0]  op;
        int          r;

        reset = 1'b1;
        drive(32'h0, 4'h0, 32'h0, 1'b0, 3'd0);
        step();
        step();
        check("reset_state", 1'b0, 32'h0, 1'b0, 1'b0, 16'h0);

        vecs.push_back(mk("lw_0_after_reset", 32'h0,  4'h0, 32'h0, 1, 3'd0, 1, 32'h0000_0000, 0, 0, 16'd0));
        vecs.push_back(mk("sw_0x10",          32'h10, 4'hF, 32'h8765_4321, 0, 3'd0, 0, 32'h0, 0, 0, 16'd1));
        vecs.push_back(mk("lb_0x13",          32'h13, 4'h0, 32'h0, 1, 3'd3, 1, 32'hFFFF_FF87, 0, 0, 16'd1));
        vecs.push_back(mk("lbu_0x13",         32'h13, 4'h0, 32'h0, 1, 3'd4, 1, 32'h0000_0087, 0, 0, 16'd1));
        vecs.push_back(mk("lh_0x12",          32'h12, 4'h0, 32'h0, 1, 3'd1, 1, 32'hFFFF_8765, 0, 0, 16'd1));
        vecs.push_back(mk("lhu_0x12",         32'h12, 4'h0, 32'h0, 1, 3'd2, 1, 32'h0000_8765, 0, 0, 16'd1));
        vecs.push_back(mk("lw_0x10",          32'h10, 4'h0, 32'h0, 1, 3'd0, 1, 32'h8765_4321, 0, 0, 16'd1));
        vecs.push_back(mk("sb_0x12",          32'h12, 4'h4, 32'h00AA_0000, 0, 3'd0, 0, 32'h0, 0, 0, 16'd2));
        vecs.push_back(mk("lw_after_sb",      32'h10, 4'h0, 32'h0, 1, 3'd0, 1, 32'h87AA_4321, 0, 0, 16'd2));
        vecs.push_back(mk("sw_misaligned",    32'h11, 4'hF, 32'hDEAD_BEEF, 0, 3'd0, 0, 32'h0, 0, 1, 16'd2));
        vecs.push_back(mk("ades_pulse_end",   32'h0,  4'h0, 32'h0, 0, 3'd0, 0, 32'h0, 0, 0, 16'd2));
        vecs.push_back(mk("lw_no_bad_write",  32'h10, 4'h0, 32'h0, 1, 3'd0, 1, 32'h87AA_4321, 0, 0, 16'd2));
        vecs.push_back(mk("sw_out_of_range",  32'h3000, 4'hF, 32'h1111_1111, 0, 3'd0, 0, 32'h0, 0, 1, 16'd2));
        vecs.push_back(mk("lw_misaligned",    32'h2,  4'h0, 32'h0, 1, 3'd0, 1, 32'h0, 1, 0, 16'd2));
        vecs.push_back(mk("lh_misaligned",    32'h5,  4'h0, 32'h0, 1, 3'd1, 1, 32'h0, 1, 0, 16'd2));
        vecs.push_back(mk("lw_out_of_range",  32'h3000, 4'h0, 32'h0, 1, 3'd0, 1, 32'h0, 1, 0, 16'd2));
        vecs.push_back(mk("lb_0x11",          32'h11, 4'h0, 32'h0, 1, 3'd3, 1, 32'h0000_0043, 0, 0, 16'd2));
        vecs.push_back(mk("lh_low_positive",  32'h10, 4'h0, 32'h0, 1, 3'd1, 1, 32'h0000_4321, 0, 0, 16'd2));
        vecs.push_back(mk("reserved_op_lw",   32'h10, 4'h0, 32'h0, 1, 3'd7, 1, 32'h87AA_4321, 0, 0, 16'd2));
        vecs.push_back(mk("sh_upper",         32'h12, 4'hC, 32'h1234_0000, 0, 3'd0, 0, 32'h0, 0, 0, 16'd3));
        vecs.push_back(mk("lw_after_sh",      32'h10, 4'h0, 32'h0, 1, 3'd0, 1, 32'h1234_4321, 0, 0, 16'd3));
        vecs.push_back(mk("sw_upper_bits",    32'h8000_0010, 4'hF, 32'h5555_5555, 0, 3'd0, 0, 32'h0, 0, 1, 16'd3));
        vecs.push_back(mk("lw_upper_bits",    32'h8000_0010, 4'h0, 32'h0, 1, 3'd0, 1, 32'h0, 1, 0, 16'd3));
        vecs.push_back(mk("sw_last_word",     32'h2FFC, 4'hF, 32'hCAFE_F00D, 0, 3'd0, 0, 32'h0, 0, 0, 16'd4));
        vecs.push_back(mk("lw_last_word",     32'h2FFC, 4'h0, 32'h0, 1, 3'd0, 1, 32'hCAFE_F00D, 0, 0, 16'd4));
        vecs.push_back(mk("lb_last_byte",     32'h2FFF, 4'h0, 32'h0, 1, 3'd3, 1, 32'hFFFF_FFCA, 0, 0, 16'd4));
        vecs.push_back(mk("sb_wrong_lane",    32'h10, 4'h2, 32'h0000_FF00, 0, 3'd0, 0, 32'h0, 0, 1, 16'd4));

        reset = 1'b0;
        foreach (vecs[i]) begin
            drive(vecs[i].addr, vecs[i].be, vecs[i].wd, vecs[i].ld, vecs[i].op);
            step();
            check(vecs[i].name, vecs[i].e_vld, vecs[i].e_rd, vecs[i].e_adel, vecs[i].e_ades,
                  vecs[i].e_cnt);
        end

        // Same-edge load and store to one word: load sees the old contents.
        drive(32'h10, 4'h1, 32'h0000_00EE, 1, 3'd0);
        step();
        check("same_cycle_ld_st_old", 1, 32'h1234_4321, 0, 0, 16'd5);
        drive(32'h10, 4'h0, 32'h0, 1, 3'd0);
        step();
        check("following_lw_new", 1, 32'h1234_43EE, 0, 0, 16'd5);

        // Four back-to-back loads with reset asserted during the third.
        drive(32'h10, 4'h0, 32'h0, 1, 3'd0);
        step();
        check("b2b_load1", 1, 32'h1234_43EE, 0, 0, 16'd5);
        drive(32'h12, 4'h0, 32'h0, 1, 3'd1);
        step();
        check("b2b_load2", 1, 32'h0000_1234, 0, 0, 16'd5);
        reset = 1'b1;
        drive(32'h10, 4'h0, 32'h0, 1, 3'd0);
        step();
        check("b2b_load3_reset", 0, 32'h0, 0, 0, 16'd0);
        reset = 1'b0;
        drive(32'h10, 4'h0, 32'h0, 1, 3'd0);
        step();
        check("b2b_load4_cleared", 1, 32'h0, 0, 0, 16'd0);
        drive(32'h2FFC, 4'h0, 32'h0, 1, 3'd0);
        step();
        check("last_word_cleared", 1, 32'h0, 0, 0, 16'd0);

        for (int i = 0; i < ADDR_WORDS; i++) model_mem[i] = 0;
        model_cnt = 0;

        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      a = 32'h100 + 32'($urandom_range(0, 31));
            else if (r < 8) a = 32'h2FF0 + 32'($urandom_range(0, 15));
            else if (r < 9) a = 32'h3000 + 32'($urandom_range(0, 255));
            else            a = (32'($urandom_range(1, 255)) << 24) | 32'($urandom_range(0, 63));
            case ($urandom_range(0, 4))
                0: be = 4'h0;
                1: be = 4'hF;
                2: be = a[1] ? 4'hC : 4'h3;
                3: be = 4'(4'b0001 << a[1:0]);
                default: be = 4'($urandom_range(0, 15));
            endcase
            wd = $urandom;
            ld = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            model_access(a, be, wd, ld, op, ev, erd, eadel, eades);
            drive(a, be, wd, ld, op);
            step();
            check($sformatf("rand_%0d_a%h_be%h_op%0d", c, a, be, op), ev, erd, eadel, eades,
                  16'(model_cnt));
        end

        drive(32'h0, 4'h0, 32'h0, 0, 3'd0);
        step();
        check("idle_outputs_zero", 0, 32'h0, 0, 0, 16'(model_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
